pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Sequential consumer of the next-PC logic's pc_src/target_address pair.
- Holds the architectural program counter and issues word-addressed fetches to instruction memory using a req/ready request and rvalid response handshake.
- Presents each fetched instruction, tagged with its PC, to decode through a valid/ready interface.
- Applies control-flow redirects, including discarding a fetch already in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
pc_src  input  1  redirect request from next-PC logic, sampled every rising edge
target_address  input  32  redirect target, valid when pc_src=1
imem_req  output  1  fetch request valid
imem_addr  output  32  word address of the fetch; equals pc_q
imem_ready  input  1  memory accepts the request this cycle (imem_req & imem_ready)
imem_rvalid  input  1  fetch response valid (one cycle pulse)
imem_rdata  input  32  fetched instruction word
instr_valid  output  1  instr/instr_pc valid to decode
instr_ready  input  1  decode accepts instruction this cycle
instr  output  32  instruction word
instr_pc  output  32  PC of instr; this is the pc fed to the next-PC logic

Behaviour:
- Reset is synchronous and active-low: rst_n=0 at a rising edge sets the following.
  - pc_q=RESET_PC, state=FETCH, drop=0.
  - instr_valid=0, instr=0, instr_pc=0.
  - Reset overrides all other inputs, including mid-transaction; no pending response is tracked afterwards.
- imem_req=1 only in FETCH. imem_addr=pc_q in all states.
- One outstanding fetch maximum.
- Addresses are word addresses; sequential increment is +1, modulo 2^32 (32'hFFFF_FFFF wraps to 0).
- FETCH:
  - imem_req=1; imem_addr is held stable until accepted.
  - On imem_ready: fetch_pc<=pc_q, state->WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with drop=0: instr<=imem_rdata, instr_pc<=fetch_pc, instr_valid<=1, pc_q<=fetch_pc+1, state->HOLD.
  - On imem_rvalid with drop=1: response discarded, drop<=0, state->FETCH.
- HOLD:
  - instr_valid=1; instr and instr_pc are held stable.
  - On instr_ready: instr_valid<=0, state->FETCH.
- Minimum sequential rate with zero-wait memory: one instruction every 3 cycles (FETCH, WAIT, HOLD).
- Redirect (pc_src=1 at an edge) has priority over all non-reset events:
  - pc_q<=target_address; instr_valid<=0.
  - FETCH without imem_ready: stay FETCH; the next request uses target_address.
  - FETCH with imem_ready same cycle: the old request was accepted, so state->WAIT and drop<=1.
  - WAIT without imem_rvalid: drop<=1, stay WAIT.
  - WAIT with imem_rvalid same cycle: response discarded, state->FETCH, drop<=0.
  - HOLD (with or without instr_ready): instruction killed, state->FETCH.
- A redirect while drop=1 updates pc_q only; drop stays 1.
- imem_rvalid outside WAIT is ignored.
- Redirect target is not modified: no alignment and no masking.

Test Plan:
- Reset, RESET_PC=0, zero-wait memory returning rdata=addr^32'hA5A5_0000, instr_ready=1 -> first imem_req on the first cycle after rst_n rises, addr 0. Decode sees instr_pc 0,1,2 with instr 32'hA5A5_0000/1/2, one every 3 cycles.
- Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr_valid stays 1, instr/instr_pc stable, imem_req=0. After ready, next fetch addr = instr_pc+1.
- Redirect in HOLD: instr_pc=0x10, pc_src=1, target=0x40 -> instr_valid drops next cycle, next imem_addr=0x40, no instruction with pc 0x11 appears.
- Redirect in WAIT, rvalid 3 cycles later: target=0x200 -> the stale response is dropped, then imem_addr=0x200; the next delivered instr_pc=0x200.
- Redirect coincident with imem_ready in FETCH, and separately coincident with rvalid in WAIT -> the stale data is never presented; the following fetch is at the target.
- Wrap and mid-operation reset: redirect to 0xFFFF_FFFF -> next sequential fetch addr 0. Assert rst_n=0 in WAIT -> next-cycle state FETCH at RESET_PC, instr_valid=0; a late rvalid arriving in FETCH is ignored.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel plus
// the valid/ready channel that hands tagged instructions to decode.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: one outstanding word-addressed fetch, hands each
// instruction to decode and applies redirects, discarding stale responses.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pc_src,
  input  logic [31:0]            target_address,
  pc_fetch_unit_if.master        bus
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_pc;
  logic        r_drop;
  logic        r_instr_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_fetch_pc_nxt;
  logic        w_drop_nxt;
  logic        w_instr_valid_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_instr_pc_nxt;

  function automatic logic [31:0] f_pc_inc(input logic [31:0] pc);
    f_pc_inc = pc + 32'd1;
  endfunction

  // Next-state and next-value logic; a redirect outranks every non-reset event.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_drop_nxt        = r_drop;
    w_instr_valid_nxt = r_instr_valid;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;

    if (pc_src) begin
      w_pc_nxt          = target_address;
      w_instr_valid_nxt = 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (bus.imem_ready) begin
            // The old request is already accepted; its response must be eaten.
            w_fetch_pc_nxt = r_pc;
            w_drop_nxt     = 1'b1;
            w_state_nxt    = ST_WAIT;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = ST_FETCH;
          end else begin
            w_drop_nxt  = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
        ST_HOLD: begin
          w_state_nxt = ST_FETCH;
        end
        default: begin
          w_drop_nxt  = 1'b0;
          w_state_nxt = ST_FETCH;
        end
      endcase
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (bus.imem_ready) begin
            w_fetch_pc_nxt = r_pc;
            w_state_nxt    = ST_WAIT;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            if (r_drop) begin
              w_drop_nxt  = 1'b0;
              w_state_nxt = ST_FETCH;
            end else begin
              w_instr_nxt       = bus.imem_rdata;
              w_instr_pc_nxt    = r_fetch_pc;
              w_instr_valid_nxt = 1'b1;
              w_pc_nxt          = f_pc_inc(r_fetch_pc);
              w_state_nxt       = ST_HOLD;
            end
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (bus.instr_ready) begin
            w_instr_valid_nxt = 1'b0;
            w_state_nxt       = ST_FETCH;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
        default: begin
          w_instr_valid_nxt = 1'b0;
          w_drop_nxt        = 1'b0;
          w_state_nxt       = ST_FETCH;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_FETCH;
      r_pc          <= RESET_PC;
      r_fetch_pc    <= 32'h0000_0000;
      r_drop        <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= 32'h0000_0000;
      r_instr_pc    <= 32'h0000_0000;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_drop        <= w_drop_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
    end
  end

  assign bus.imem_req    = (r_state == ST_FETCH);
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a behavioural instruction memory that
// answers each accepted fetch after a programmable latency with addr^A5A5_0000.
module tb_pc_fetch_unit;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_src;
  logic [31:0] target_address;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_src         (pc_src),
    .target_address (target_address),
    .bus            (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Memory model: acceptance captured at the rising edge, response driven at the falling edge.
  logic        acc = 1'b0;
  logic [31:0] acc_addr = 32'h0;
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'h0;
  int          cnt = 0;
  int          lat = 0;

  always @(posedge clk) begin
    acc      = bus.imem_req && bus.imem_ready;
    acc_addr = bus.imem_addr;
  end

  always @(negedge clk) begin
    bus.imem_rvalid = 1'b0;
    if (acc) begin
      pend  = 1'b1;
      paddr = acc_addr;
      cnt   = lat;
    end
    if (pend) begin
      if (cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = paddr ^ K;
        pend            = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    pc_src          = 1'b0;
    target_address  = 32'h0;
    bus.imem_ready  = 1'b1;
    bus.instr_ready = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;

    // Reset state
    step(); step();
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rst_addr", bus.imem_addr, 32'h0);
    rst_n = 1'b1;

    // Zero-wait sequential stream: FETCH, WAIT, HOLD per instruction
    for (int k = 0; k < 3; k++) begin
      step();
      chk("seq_wait_req", {31'd0, bus.imem_req}, 32'd0);
      chk("seq_wait_valid", {31'd0, bus.instr_valid}, 32'd0);
      step();
      chk("seq_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("seq_pc", bus.instr_pc, 32'(k));
      chk("seq_instr", bus.instr, K ^ 32'(k));
      step();
      chk("seq_next_req", {31'd0, bus.imem_req}, 32'd1);
      chk("seq_next_addr", bus.imem_addr, 32'(k + 1));
    end

    // Decode backpressure for 5 cycles in HOLD
    bus.instr_ready = 1'b0;
    step(); step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("bp_pc", bus.instr_pc, 32'h3);
      chk("bp_instr", bus.instr, 32'hA5A5_0003);
      chk("bp_req", {31'd0, bus.imem_req}, 32'd0);
    end
    bus.instr_ready = 1'b1;
    step();
    chk("bp_next_addr", bus.imem_addr, 32'h4);
    chk("bp_next_req", {31'd0, bus.imem_req}, 32'd1);

    // Redirect in FETCH without ready, then redirect in HOLD
    bus.imem_ready = 1'b0; pc_src = 1'b1; target_address = 32'h10;
    step();
    chk("rf_addr", bus.imem_addr, 32'h10);
    chk("rf_req", {31'd0, bus.imem_req}, 32'd1);
    bus.imem_ready = 1'b1; pc_src = 1'b0;
    step(); step();
    chk("rh_pre_pc", bus.instr_pc, 32'h10);
    chk("rh_pre_instr", bus.instr, 32'hA5A5_0010);
    pc_src = 1'b1; target_address = 32'h40;
    step();
    chk("rh_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rh_addr", bus.imem_addr, 32'h40);
    pc_src = 1'b0;
    step(); step();
    chk("rh_next_pc", bus.instr_pc, 32'h40);
    chk("rh_next_valid", {31'd0, bus.instr_valid}, 32'd1);
    step();
    chk("rh_seq_addr", bus.imem_addr, 32'h41);

    // Redirect in WAIT with a slow response
    lat = 2;
    step();
    chk("rw_wait_req", {31'd0, bus.imem_req}, 32'd0);
    pc_src = 1'b1; target_address = 32'h200;
    step();
    chk("rw_addr", bus.imem_addr, 32'h200);
    chk("rw_req", {31'd0, bus.imem_req}, 32'd0);
    pc_src = 1'b0;
    step();
    chk("rw_still_wait", {31'd0, bus.imem_req}, 32'd0);
    step();
    chk("rw_drop_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rw_drop_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rw_drop_addr", bus.imem_addr, 32'h200);
    lat = 0;
    step(); step();
    chk("rw_pc", bus.instr_pc, 32'h200);
    chk("rw_instr", bus.instr, 32'hA5A5_0200);
    step();
    chk("rw_seq_addr", bus.imem_addr, 32'h201);

    // Redirect coincident with acceptance in FETCH
    pc_src = 1'b1; target_address = 32'h300;
    step();
    chk("ra_req", {31'd0, bus.imem_req}, 32'd0);
    chk("ra_addr", bus.imem_addr, 32'h300);
    pc_src = 1'b0;
    step();
    chk("ra_drop_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("ra_drop_req", {31'd0, bus.imem_req}, 32'd1);
    chk("ra_drop_addr", bus.imem_addr, 32'h300);
    step(); step();
    chk("ra_pc", bus.instr_pc, 32'h300);
    chk("ra_instr", bus.instr, 32'hA5A5_0300);
    step();

    // Redirect coincident with the response in WAIT
    step();
    pc_src = 1'b1; target_address = 32'h400;
    step();
    chk("rv_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rv_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rv_addr", bus.imem_addr, 32'h400);
    pc_src = 1'b0;
    step(); step();
    chk("rv_pc", bus.instr_pc, 32'h400);
    chk("rv_instr", bus.instr, 32'hA5A5_0400);
    step();

    // Wrap from 0xFFFF_FFFF to 0
    bus.imem_ready = 1'b0; pc_src = 1'b1; target_address = 32'hFFFF_FFFF;
    step();
    chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFF);
    bus.imem_ready = 1'b1; pc_src = 1'b0;
    step(); step();
    chk("wr_pc", bus.instr_pc, 32'hFFFF_FFFF);
    chk("wr_instr", bus.instr, 32'h5A5A_FFFF);
    step();
    chk("wr_next_addr", bus.imem_addr, 32'h0);
    step(); step(); step();
    chk("mr_pre_addr", bus.imem_addr, 32'h1);

    // Reset while a slow fetch is in flight; the late response lands in FETCH
    lat = 2;
    step();
    chk("mr_wait_req", {31'd0, bus.imem_req}, 32'd0);
    rst_n = 1'b0; bus.imem_ready = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_req", {31'd0, bus.imem_req}, 32'd1);
    chk("mr_addr", bus.imem_addr, 32'h0);
    chk("mr_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("mr_instr", bus.instr, 32'h0);
    step(); step();
    chk("mr_late_req", {31'd0, bus.imem_req}, 32'd1);
    chk("mr_late_valid", {31'd0, bus.instr_valid}, 32'd0);
    step();
    chk("mr_late_valid2", {31'd0, bus.instr_valid}, 32'd0);
    chk("mr_late_addr", bus.imem_addr, 32'h0);
    lat = 0; bus.imem_ready = 1'b1;
    step(); step();
    chk("mr_pc", bus.instr_pc, 32'h0);
    chk("mr_instr_val", bus.instr, 32'hA5A5_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
